// File: rtl/mult_pipe_pkg.sv
// Shared constants and helpers for the elastic fixed-point multiplier.
// Latency bounds and the stage that registers the post-processed result.
package mult_pipe_pkg;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  // Stages past the result stage are pure delay; stages before it hold operands/product.
  function automatic int result_stage(input int latency);
    return (latency >= 3) ? 3 : latency;
  endfunction

endpackage

// File: rtl/mult_pipe_postproc.sv
// Product post-processing: floor shift, slice to BW_OUT, wrap or clamp, overflow flag.
// Purely combinational; no handshake of its own.
module mult_postproc #(
  parameter int BW_BUF = 64,
  parameter int SHIFT  = 0,
  parameter int SAT    = 0,
  parameter int BW_OUT = 32
) (
  input  logic [BW_BUF-1:0] prod,
  input  logic              sgn,
  output logic [BW_OUT-1:0] res,
  output logic              ovf
);

  localparam int BW_R = BW_BUF - SHIFT;
  localparam logic [BW_OUT-1:0] MAX_S = {1'b0, {(BW_OUT-1){1'b1}}};
  localparam logic [BW_OUT-1:0] MIN_S = {1'b1, {(BW_OUT-1){1'b0}}};
  localparam logic [BW_OUT-1:0] MAX_U = '1;

  logic signed [BW_BUF-1:0] sh_s;
  logic        [BW_BUF-1:0] sh_u;
  logic        [BW_BUF-1:0] r;

  // Separate shifts so the signed one stays arithmetic (floor) regardless of the mux.
  assign sh_s = $signed(prod) >>> SHIFT;
  assign sh_u = prod >> SHIFT;
  assign r    = sgn ? sh_s : sh_u;

  generate
    if (BW_OUT >= BW_R) begin : g_fit
      assign res = sgn ? BW_OUT'($signed(r)) : BW_OUT'(r);
      assign ovf = 1'b0;
    end else begin : g_slice
      logic [BW_BUF-BW_OUT:0] top;
      logic                   lost;

      // Dropped MSBs plus out's MSB must all agree for a signed result to be intact.
      assign top  = r[BW_BUF-1:BW_OUT-1];
      assign lost = sgn ? !((&top) || !(|top)) : (|top[BW_BUF-BW_OUT:1]);
      assign ovf  = lost;

      always_comb begin
        res = r[BW_OUT-1:0];
        if ((SAT != 0) && lost) begin
          res = sgn ? (r[BW_BUF-1] ? MIN_S : MAX_S) : MAX_U;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mult_pipe.sv
// Elastic pipelined multiplier with per-operand signedness, LSB drop and wrap/saturate output.
// LATENCY register stages, 1 result/cycle; any empty stage fills while downstream stalls.
module mult_pipe
  import mult_pipe_pkg::*;
#(
  parameter int BW_INPUT0 = 32,
  parameter int BW_INPUT1 = 32,
  parameter int SIGNED0   = 0,
  parameter int SIGNED1   = 0,
  parameter int BW_OUT    = 32,
  parameter int SHIFT     = 0,
  parameter int SAT       = 0,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BW_INPUT0-1:0] in0,
  input  logic [BW_INPUT1-1:0] in1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BW_OUT-1:0]    out,
  output logic                 out_ovf
);

  localparam int   BW_BUF  = BW_INPUT0 + BW_INPUT1;
  localparam int   RES_STG = result_stage(LATENCY);
  localparam logic PSGN    = (SIGNED0 != 0) || (SIGNED1 != 0);

  generate
    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
      $error("mult_pipe: LATENCY must be 1..4");
    end
    if (SHIFT < 0 || SHIFT >= BW_BUF) begin : g_bad_shift
      $error("mult_pipe: SHIFT must be below BW_INPUT0+BW_INPUT1");
    end
  endgenerate

  logic [LATENCY:1]   vld;
  logic [LATENCY:1]   vin;
  logic [LATENCY:1]   ld;
  logic [LATENCY+1:1] rdy;

  always_comb begin
    vin    = '0;
    vin[1] = in_valid;
    for (int i = 2; i <= LATENCY; i++) vin[i] = vld[i-1];
  end

  // A stage can load if any stage from it to the output is empty, or the consumer takes the head.
  always_comb begin
    rdy = '0;
    for (int i = 1; i <= LATENCY + 1; i++) begin
      rdy[i] = out_ready;
      for (int j = i; j <= LATENCY; j++) begin
        if (!vld[j]) rdy[i] = 1'b1;
      end
    end
  end

  assign ld = vin & rdy[LATENCY:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      for (int i = 1; i <= LATENCY; i++) begin
        if (rdy[i]) vld[i] <= vin[i];
      end
    end
  end

  logic [BW_INPUT0-1:0] m_a;
  logic [BW_INPUT1-1:0] m_b;

  generate
    if (LATENCY == 1) begin : g_opr_comb
      assign m_a = in0;
      assign m_b = in1;
    end else begin : g_opr_reg
      logic [BW_INPUT0-1:0] a_q;
      logic [BW_INPUT1-1:0] b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld[1]) begin
          a_q <= in0;
          b_q <= in1;
        end
      end
      assign m_a = a_q;
      assign m_b = b_q;
    end
  endgenerate

  // One extra MSB per operand lets a single signed multiply cover every signedness mix.
  logic signed [BW_INPUT0:0]   a_x;
  logic signed [BW_INPUT1:0]   b_x;
  logic signed [BW_BUF-1:0]    a_w;
  logic signed [BW_BUF-1:0]    b_w;
  logic        [BW_BUF-1:0]    prod;
  logic        [BW_BUF-1:0]    pp_in;
  logic        [BW_OUT-1:0]    pp_res;
  logic                        pp_ovf;

  assign a_x  = {(SIGNED0 != 0) & m_a[BW_INPUT0-1], m_a};
  assign b_x  = {(SIGNED1 != 0) & m_b[BW_INPUT1-1], m_b};
  assign a_w  = BW_BUF'(a_x);
  assign b_w  = BW_BUF'(b_x);
  assign prod = a_w * b_w;

  generate
    if (LATENCY >= 3) begin : g_prod_reg
      logic [BW_BUF-1:0] p_q;
      always_ff @(posedge clk) begin
        if (rst)        p_q <= '0;
        else if (ld[2]) p_q <= prod;
      end
      assign pp_in = p_q;
    end else begin : g_prod_comb
      assign pp_in = prod;
    end
  endgenerate

  mult_postproc #(
    .BW_BUF (BW_BUF),
    .SHIFT  (SHIFT),
    .SAT    (SAT),
    .BW_OUT (BW_OUT)
  ) u_postproc (
    .prod (pp_in),
    .sgn  (PSGN),
    .res  (pp_res),
    .ovf  (pp_ovf)
  );

  logic [BW_OUT-1:0] res_q;
  logic              ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      ovf_q <= 1'b0;
    end else if (ld[RES_STG]) begin
      res_q <= pp_res;
      ovf_q <= pp_ovf;
    end
  end

  generate
    if (LATENCY == 4) begin : g_delay
      logic [BW_OUT-1:0] d_q;
      logic              d_ovf;
      always_ff @(posedge clk) begin
        if (rst) begin
          d_q   <= '0;
          d_ovf <= 1'b0;
        end else if (ld[4]) begin
          d_q   <= res_q;
          d_ovf <= ovf_q;
        end
      end
      assign out     = d_q;
      assign out_ovf = d_ovf;
    end else begin : g_no_delay
      assign out     = res_q;
      assign out_ovf = ovf_q;
    end
  endgenerate

  assign out_valid = vld[LATENCY];
  assign in_ready  = rdy[1];

endmodule
